// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end for the RISC-V core.
//   Sends in-order word fetches to instruction memory and receives in-order,
//   variable-latency responses. Fetched instructions are kept with their PCs
//   in a show-ahead prefetch FIFO and handed to decode over valid/ready.
//   A redirect flushes the FIFO, marks every in-flight fetch for discard and
//   restarts fetch at the (word-aligned) target.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   imem_req_valid/ready/addr   fetch request channel
//   imem_rsp_valid/data         fetch response channel (in order)
//   redirect, redirect_pc       fetch restart from the core
//   if_valid/ready, if_instr/pc instruction delivery to decode
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t [DEPTH-1:0] fifo;

  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0]   count, outstanding, drop, out_next, count_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            accept, push, pop, has_data;

  always_comb begin
    has_data      = (count != '0);
    target        = {redirect_pc[XLEN-1:2], 2'b00};
    // Requests are capped so every outstanding fetch already owns a FIFO slot;
    // the response path therefore never needs to check for space.
    imem_req_valid = rst && !redirect && (({1'b0, count} + {1'b0, outstanding}) < CAP);
    imem_req_addr  = fetch_pc;
    accept        = imem_req_valid && imem_req_ready;
    if_valid      = has_data && !redirect;
    pop           = if_valid && if_ready;
    push          = imem_rsp_valid && !redirect && (drop == '0);
    out_next      = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    count_next    = count + CW'(push) - CW'(pop);
    // Empty head reads as zero so nothing stale leaks out after a flush.
    if_instr      = has_data ? fifo[rd_ptr].instr : '0;
    if_pc         = has_data ? fifo[rd_ptr].pc    : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect) begin
      fetch_pc    <= target;
      rsp_pc      <= target;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= out_next;
      // Everything still in flight after this cycle belongs to the old path.
      drop        <= out_next;
    end else begin
      if (accept) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= out_next;
      if (imem_rsp_valid) begin
        if (drop != '0) drop   <= drop - CW'(1);
        else            rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (rst && push) fifo[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front-end sitting directly upstream of the RISC-V core's decode/execute.
- Issues in-order word fetches to an instruction memory with a valid/ready request channel and variable-latency in-order responses.
- Buffers fetched instructions with their PCs in a prefetch FIFO and presents them to the core through a valid/ready handshake.
- On a taken branch or jump, the core's redirect flushes the FIFO, discards in-flight responses, and restarts fetch at the target.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus outstanding requests. Must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- imem_req_valid  out  1  a fetch request is offered.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; in order, at most 1 per cycle, no earlier than 1 cycle after acceptance.
- imem_rsp_data  in  XLEN  fetched instruction.
- redirect  in  1  core requests a fetch restart.
- redirect_pc  in  XLEN  restart target; bits [1:0] are forced to 0 internally.
- if_valid  out  1  if_instr and if_pc are valid.
- if_ready  in  1  core consumes the head entry.
- if_instr  out  XLEN  instruction at the FIFO head.
- if_pc  out  XLEN  PC of if_instr.

Behaviour:
- Reset (rst==0 at a posedge), which overrides everything including redirect:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - Outputs: imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0 (empty head reads as zero), imem_req_addr=RESET_PC.
- Internal counters: outstanding, drop and count are each $clog2(DEPTH)+1 bits. Invariant: count+outstanding <= DEPTH; they never wrap.
- Request channel:
  - imem_req_valid = rst && !redirect && (count+outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On acceptance (valid && ready): fetch_pc += 4 (wraps mod 2^XLEN) and outstanding increments.
  - Once asserted, valid holds with a stable address until accepted, unless redirect intervenes.
- Response channel:
  - Each imem_rsp_valid decrements outstanding; a same-cycle accept and response leave it unchanged.
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise: push {rsp_pc, imem_rsp_data} and rsp_pc += 4. Space is guaranteed by the invariant.
  - imem_rsp_valid with outstanding==0 is illegal; the assertion in the bench must flag it.
- Output:
  - Show-ahead FIFO; if_valid = (count!=0) && !redirect.
  - Pop when if_valid && if_ready; if_instr/if_pc update on the following cycle.
  - Push and pop in the same cycle keep count unchanged. A push into an empty FIFO is visible the next cycle, so response-to-if_valid latency is 1 cycle.
- Redirect (sampled at posedge, rst==1):
  - FIFO cleared (count=0, pointers=0).
  - fetch_pc and rsp_pc are loaded with {redirect_pc[XLEN-1:2],2'b00}.
  - No request is issued that cycle.
  - drop = outstanding after this cycle's response decrement, i.e. every in-flight request is discarded.
  - A response arriving in the redirect cycle is discarded; it reduces outstanding and is not counted in drop.
  - Back-to-back redirects: each reloads the PCs, and drop is recomputed from the current outstanding count.
  - The first request to the new target appears in the cycle after redirect deasserts.
- if_ready while if_valid==0 has no effect. if_ready in a redirect cycle pops nothing.

Test Plan:
- Reset then streaming:
  - Stimulus: rst low 2 cycles, then high; memory ready=1, fixed 1-cycle latency, if_ready=1.
  - Required: addresses 0,4,8,... on consecutive cycles; if_pc 0,4,8,... on consecutive cycles starting 2 cycles after the first accept; instr matches memory.
- Backpressure:
  - Stimulus: if_ready=0, memory ready=1.
  - Required: exactly DEPTH=4 requests accepted (0..C), then imem_req_valid=0; FIFO holds 4 entries. Raising if_ready drains 0,4,8,C in order and fetching resumes at 0x10.
- Variable latency and stall:
  - Stimulus: imem_req_ready toggles 1,0,0,1; responses spaced randomly 1-3 cycles.
  - Required: addresses are held stable while ready=0; if_pc sequence is strictly +4 with no gaps or duplicates.
- Redirect with in-flight requests:
  - Stimulus: 3 outstanding requests (0x10,0x14,0x18); redirect=1 with redirect_pc=0x103 for 1 cycle.
  - Required: drop=3; next request is 0x100; all 3 old responses are discarded; first if_pc=0x100.
- Redirect with a same-cycle response, plus back-to-back redirects:
  - Stimulus: redirect asserted together with imem_rsp_valid, then redirects in 2 consecutive cycles to 0x200 and then 0x300.
  - Required: no stale instruction is ever presented; the first delivered if_pc is 0x300; outstanding and drop return to 0.
- Reset mid-operation:
  - Stimulus: rst low while FIFO is full and 0 outstanding, with redirect=1 in the same cycle.
  - Required: all outputs are at reset values next cycle, and fetch restarts at RESET_PC, not redirect_pc.
